// File: rtl/muldiv_unit.sv
// Iterative signed multiply (radix-2 Booth) / divide (restoring) into {hi,lo}; done WIDTH+1 cycles after start, start ignored while busy.
// Divider present only when MULTDIV_DIV_EN is defined; otherwise op=1 completes after one cycle with hi/lo untouched.
module muldiv_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
   input  logic             op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             busy,
   output logic             done,
   output logic             div_zero
);
   typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;
   localparam int CW = $clog2(WIDTH + 1);

   state_t           state, state_nxt;
   logic [CW-1:0]    count;
   logic             op_q;
   logic             skip;
   logic [2*WIDTH:0] acc;        // {A, Q, q_-1}
   logic [WIDTH-1:0] mcand;
   logic [WIDTH:0]   booth_sum;

`ifdef MULTDIV_DIV_EN
   logic [WIDTH-1:0] rem, quo, dvs, rem_shift;
   logic             neg_q, neg_r, dz_q, ge;

   function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x);
      return x[WIDTH-1] ? -x : x;
   endfunction

   // The shifted remainder is WIDTH+1 bits wide, but its top bit only matters
   // for the compare: a successful subtraction always lands below dvs.
   assign skip      = op && (b == '0);
   assign rem_shift = {rem[WIDTH-2:0], quo[WIDTH-1]};
   assign ge        = {rem, quo[WIDTH-1]} >= {1'b0, dvs};
`else
   assign skip = op;
`endif

   always_comb begin
      booth_sum = {acc[2*WIDTH], acc[2*WIDTH:WIDTH+1]};
      case (acc[1:0])
         2'b01:   booth_sum = {acc[2*WIDTH], acc[2*WIDTH:WIDTH+1]} + {mcand[WIDTH-1], mcand};
         2'b10:   booth_sum = {acc[2*WIDTH], acc[2*WIDTH:WIDTH+1]} - {mcand[WIDTH-1], mcand};
         default: ;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      busy      = 1'b0;
      case (state)
         IDLE: if (start) state_nxt = skip ? FIX : RUN;
         RUN: begin
            busy = 1'b1;
            if (count == CW'(1)) state_nxt = FIX;
         end
         FIX: begin
            busy      = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         hi       <= '0;
         lo       <= '0;
         done     <= 1'b0;
         div_zero <= 1'b0;
         count    <= '0;
         op_q     <= 1'b0;
         acc      <= '0;
         mcand    <= '0;
`ifdef MULTDIV_DIV_EN
         rem      <= '0;
         quo      <= '0;
         dvs      <= '0;
         neg_q    <= 1'b0;
         neg_r    <= 1'b0;
         dz_q     <= 1'b0;
`endif
      end else begin
         done     <= 1'b0;
         div_zero <= 1'b0;
         case (state)
            IDLE: if (start) begin
               op_q  <= op;
               count <= CW'(WIDTH);
               acc   <= {{WIDTH{1'b0}}, b, 1'b0};
               mcand <= a;
`ifdef MULTDIV_DIV_EN
               rem   <= '0;
               quo   <= mag(a);
               dvs   <= mag(b);
               neg_q <= a[WIDTH-1] ^ b[WIDTH-1];
               neg_r <= a[WIDTH-1];
               dz_q  <= skip;
`endif
            end
            RUN: begin
               count <= count - CW'(1);
               if (!op_q) acc <= {booth_sum, acc[WIDTH:1]};
`ifdef MULTDIV_DIV_EN
               else begin
                  rem <= ge ? rem_shift - dvs : rem_shift;
                  quo <= {quo[WIDTH-2:0], ge};
               end
`endif
            end
            FIX: begin
               done <= 1'b1;
               if (!op_q) {hi, lo} <= acc[2*WIDTH:1];
`ifdef MULTDIV_DIV_EN
               else if (dz_q) div_zero <= 1'b1;
               else begin
                  lo <= neg_q ? -quo : quo;
                  hi <= neg_r ? -rem : rem;
               end
`endif
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: vector table, hand sequences and random ops against an arithmetic model.
module tb_muldiv_unit;
`ifdef MULTDIV_DIV_EN
   localparam bit DIV_EN = 1'b1;
`else
   localparam bit DIV_EN = 1'b0;
`endif

   logic        clock, reset, start, op, busy, done, div_zero;
   logic [31:0] a, b, hi, lo;
   logic        start8, op8, busy8, done8, dz8;
   logic [7:0]  a8, b8, hi8, lo8;

   int          tests = 0, fails = 0;
   logic [31:0] exp_hi, exp_lo, mod_hi, mod_lo;
   logic        exp_dz;
   int          exp_lat;

   typedef struct {
      logic        op;
      logic [31:0] a, b, hi, lo;
      logic        dz, b2b;
   } vec_t;
   vec_t vecs[9];

   muldiv_unit #(.WIDTH(32)) dut (
      .clock(clock), .reset(reset), .start(start), .op(op), .a(a), .b(b),
      .hi(hi), .lo(lo), .busy(busy), .done(done), .div_zero(div_zero));

   muldiv_unit #(.WIDTH(8)) dut8 (
      .clock(clock), .reset(reset), .start(start8), .op(op8), .a(a8), .b(b8),
      .hi(hi8), .lo(lo8), .busy(busy8), .done(done8), .div_zero(dz8));

   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
      tests++;
      if (act !== expv) begin
         fails++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, expv);
      end
   endtask

   // Reference: plain signed arithmetic on 64-bit integers.
   task automatic model(input logic o, input logic [31:0] x, input logic [31:0] y);
      longint sx, sy, p;
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      exp_dz = 1'b0; exp_lat = 33; exp_hi = mod_hi; exp_lo = mod_lo;
      if (!o) begin
         p = sx * sy;
         exp_hi = p[63:32];
         exp_lo = p[31:0];
      end else if (!DIV_EN) begin
         exp_lat = 1;
      end else if (sy == 0) begin
         exp_lat = 1;
         exp_dz  = 1'b1;
      end else begin
         exp_lo = 32'(sx / sy);
         exp_hi = 32'(sx % sy);
      end
   endtask

   task automatic issue(input logic o, input logic [31:0] x, input logic [31:0] y);
      start = 1'b1; op = o; a = x; b = y;
      @(posedge clock); #1;
      start = 1'b0; op = 1'($urandom); a = $urandom; b = $urandom;
   endtask

   task automatic wait_done(input string nm, input int inj);
      int lat = 0;
      bit busy_ok = 1'b1;
      @(negedge clock);
      while (!done && lat < 200) begin
         if (!busy) busy_ok = 1'b0;
         if (inj != 0 && lat == inj) begin
            start = 1'b1; op = 1'b0; a = $urandom; b = $urandom;
         end else start = 1'b0;
         @(negedge clock);
         lat++;
      end
      start = 1'b0;
      chk({nm, ".lat"}, 64'(lat), 64'(exp_lat));
      chk({nm, ".busy_run"}, 64'(busy_ok), 64'd1);
      chk({nm, ".busy_done"}, 64'(busy), 64'd0);
      chk({nm, ".hilo"}, {hi, lo}, {exp_hi, exp_lo});
      chk({nm, ".div_zero"}, 64'(div_zero), 64'(exp_dz));
      mod_hi = exp_hi;
      mod_lo = exp_lo;
   endtask

   task automatic run8(input logic [7:0] x, input logic [7:0] y,
                       input logic [7:0] eh, input logic [7:0] el, input string nm);
      int lat = 0;
      start8 = 1'b1; a8 = x; b8 = y;
      @(posedge clock); #1;
      start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom);
      @(negedge clock);
      while (!done8 && lat < 100) begin
         @(negedge clock);
         lat++;
      end
      chk({nm, ".lat"}, 64'(lat), 64'd9);
      chk({nm, ".hilo"}, 64'({hi8, lo8}), 64'({eh, el}));
      chk({nm, ".busy"}, 64'(busy8), 64'd0);
   endtask

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 5))
         0:       return 32'h0000_0000;
         1:       return 32'hFFFF_FFFF;
         2:       return 32'h8000_0000;
         3:       return 32'h7FFF_FFFF;
         4:       return 32'($urandom_range(0, 20)) - 32'd10;
         default: return $urandom;
      endcase
   endfunction

   initial begin
      bit seen;
      logic signed [15:0] p8;
      logic [7:0] x8, y8;

      //          op    a             b             hi            lo            dz    b2b
      vecs[0] = '{1'b0, 32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 1'b0};
      vecs[1] = '{1'b0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0, 1'b0};
      vecs[2] = '{1'b0, 32'h0000_FFFF, 32'h0000_FFFF, 32'h0000_0000, 32'hFFFE_0001, 1'b0, 1'b1};
      vecs[3] = '{1'b1, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 1'b0};
      vecs[4] = '{1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0, 1'b1};
      vecs[5] = '{1'b1, 32'd5,        32'd0,        32'h0000_0000, 32'h8000_0000, 1'b1, 1'b0};
      vecs[6] = '{1'b1, 32'd7,        32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0, 1'b1};
      vecs[7] = '{1'b1, 32'hFFFF_FFF8, 32'hFFFF_FFFD, 32'hFFFF_FFFE, 32'h0000_0002, 1'b0, 1'b0};
      vecs[8] = '{1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001, 1'b0, 1'b1};

      reset = 1'b1; start = 1'b0; op = 1'b0; a = '0; b = '0;
      start8 = 1'b0; op8 = 1'b0; a8 = '0; b8 = '0;
      mod_hi = '0; mod_lo = '0;
      repeat (3) @(negedge clock);
      chk("rst.hilo", {hi, lo}, 64'd0);
      chk("rst.ctl", 64'({busy, done, div_zero}), 64'd0);
      reset = 1'b0;
      @(negedge clock);

      for (int i = 0; i < 9; i++) begin
         if (!vecs[i].b2b) repeat (2) @(negedge clock);
         exp_hi = vecs[i].hi; exp_lo = vecs[i].lo; exp_dz = vecs[i].dz;
         exp_lat = (vecs[i].op && (!DIV_EN || vecs[i].b == 32'd0)) ? 1 : 33;
         if (vecs[i].op && !DIV_EN) begin
            exp_hi = mod_hi; exp_lo = mod_lo; exp_dz = 1'b0;
         end
         issue(vecs[i].op, vecs[i].a, vecs[i].b);
         wait_done($sformatf("vec%0d", i), 0);
      end

      @(negedge clock);
      chk("pulse.after", 64'({done, div_zero}), 64'd0);

      // start while busy must not disturb the operation in flight
      model(1'b0, 32'h1234_5678, 32'hFEDC_BA98);
      issue(1'b0, 32'h1234_5678, 32'hFEDC_BA98);
      wait_done("ignored_start", 10);

      // reset in the middle of an operation: outputs clear, no done follows
      issue(1'b0, 32'd1000, 32'd3000);
      repeat (19) @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      chk("midrst.hilo", {hi, lo}, 64'd0);
      chk("midrst.ctl", 64'({busy, done, div_zero}), 64'd0);
      seen = 1'b0;
      repeat (45) begin
         @(negedge clock);
         if (done) seen = 1'b1;
      end
      chk("midrst.nodone", 64'(seen), 64'd0);
      mod_hi = '0; mod_lo = '0;

      // reset wins over a simultaneous start
      reset = 1'b1; start = 1'b1; op = 1'b0; a = 32'd5; b = 32'd5;
      @(negedge clock);
      reset = 1'b0; start = 1'b0;
      chk("rst_start.busy", 64'(busy), 64'd0);
      seen = 1'b0;
      repeat (40) begin
         @(negedge clock);
         if (done) seen = 1'b1;
      end
      chk("rst_start.nodone", 64'(seen), 64'd0);

      model(1'b0, 32'd3, 32'd4);
      issue(1'b0, 32'd3, 32'd4);
      wait_done("post_rst", 0);

      for (int i = 0; i < 40; i++) begin
         logic o;
         logic [31:0] x, y;
         o = 1'($urandom_range(0, 1));
         x = pick();
         y = pick();
         model(o, x, y);
         issue(o, x, y);
         wait_done($sformatf("rnd%0d", i), (i % 5 == 0) ? 7 : 0);
         if (i % 3 == 0) begin
            @(negedge clock);
            chk("rnd.pulse", 64'({done, div_zero}), 64'd0);
         end
      end

      run8(8'h80, 8'h80, 8'h40, 8'h00, "w8_minmin");
      run8(8'h07, 8'hFD, 8'hFF, 8'hEB, "w8_7x-3");
      run8(8'h7F, 8'h80, 8'hC0, 8'h80, "w8_maxmin");
      for (int i = 0; i < 8; i++) begin
         x8 = 8'($urandom);
         y8 = 8'($urandom);
         p8 = 16'($signed(x8)) * 16'($signed(y8));
         run8(x8, y8, p8[15:8], p8[7:0], "w8_rnd");
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
